txn_checker: RTL

Synthesizable, parametrised transaction checker that replaces the single-transaction software compare in our driver/monitor/scoreboard flow with an in-fabric scoreboard. Expected transactions (address + data) are queued from the stimulus side; observed transactions from the DUT output side are compared in order against the queue head. Match/mismatch/unexpected counts, first-error capture and a watchdog timeout are reported as registered outputs for the bench or an on-chip debug bus.

---
 rtl/txn_checker.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/txn_checker.sv
// In-order transaction checker: queues expected (addr, data) pairs, compares observations
// against the queue head and reports counts, first-error capture and a watchdog timeout.
// Optional macro TXN_CHECKER_HALT_EN: freeze the checker on the first error.
module txn_checker #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     exp_valid_i,
    output logic                     exp_ready_o,
    input  logic [ADDR_W-1:0]        exp_addr_i,
    input  logic [DATA_W-1:0]        exp_data_i,
    input  logic                     obs_valid_i,
    input  logic [ADDR_W-1:0]        obs_addr_i,
    input  logic [DATA_W-1:0]        obs_data_i,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic [CNT_W-1:0]         match_cnt_o,
    output logic [CNT_W-1:0]         mismatch_cnt_o,
    output logic [CNT_W-1:0]         unexp_cnt_o,
    output logic                     err_o,
    output logic [ADDR_W-1:0]        err_addr_o,
    output logic [DATA_W-1:0]        err_exp_data_o,
    output logic [DATA_W-1:0]        err_obs_data_o,
    output logic                     timeout_o
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e                   state_q, state_d;
    logic [AW:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]         match_q, match_d, mism_q, mism_d, unexp_q, unexp_d;
    logic                     err_q, err_d, timeout_q, timeout_d;
    logic [ADDR_W-1:0]        err_addr_q, err_addr_d;
    logic [DATA_W-1:0]        err_exp_q, err_exp_d, err_obs_q, err_obs_d;
    logic [WdW-1:0]           wd_q, wd_d;

    logic              full, empty, push, obs_act, pop, hit, is_mism, is_unexp, err_evt;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign {head_addr, head_data} = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
        empty    = wr_ptr_q == rd_ptr_q;
        exp_ready_o = !full && (state_q == StRun);
        push     = exp_valid_i && exp_ready_o;
        obs_act  = obs_valid_i && (state_q == StRun);
        pop      = obs_act && !empty;
        hit      = (head_addr == obs_addr_i) && (head_data == obs_data_i);
        is_mism  = pop && !hit;
        is_unexp = obs_act && empty;
        err_evt  = is_mism || is_unexp;

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        match_d    = match_q;
        mism_d     = mism_q;
        unexp_d    = unexp_q;
        err_d      = err_q || err_evt;
        err_addr_d = err_addr_q;
        err_exp_d  = err_exp_q;
        err_obs_d  = err_obs_q;
        timeout_d  = timeout_q;
        wd_d       = wd_q;

        if (pop && hit && match_q != '1) match_d = match_q + 1'b1;
        if (is_mism && mism_q != '1)     mism_d  = mism_q + 1'b1;
        if (is_unexp && unexp_q != '1)   unexp_d = unexp_q + 1'b1;

        // Only the first error since reset/clear is captured.
        if (err_evt && !err_q) begin
            err_addr_d = obs_addr_i;
            err_exp_d  = is_mism ? head_data : '0;
            err_obs_d  = obs_data_i;
        end

`ifdef TXN_CHECKER_HALT_EN
        if (err_evt) state_d = StHalt;
`endif

        if (obs_act || empty) begin
            wd_d = '0;
        end else if (wd_q != WdMax) begin
            wd_d = wd_q + 1'b1;
        end
        if (wd_d == WdMax && !empty) timeout_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {exp_addr_i, exp_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q    <= StRun;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            match_q    <= '0;
            mism_q     <= '0;
            unexp_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_obs_q  <= '0;
            timeout_q  <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            match_q    <= match_d;
            mism_q     <= mism_d;
            unexp_q    <= unexp_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            err_exp_q  <= err_exp_d;
            err_obs_q  <= err_obs_d;
            timeout_q  <= timeout_d;
            wd_q       <= wd_d;
        end
    end

    assign pending_o      = wr_ptr_q - rd_ptr_q;
    assign match_cnt_o    = match_q;
    assign mismatch_cnt_o = mism_q;
    assign unexp_cnt_o    = unexp_q;
    assign err_o          = err_q;
    assign err_addr_o     = err_addr_q;
    assign err_exp_data_o = err_exp_q;
    assign err_obs_data_o = err_obs_q;
    assign timeout_o      = timeout_q;

endmodule
